// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and coin values for the guffin vending controller
// Contents:
//   vend_state_t : controller state, encoded for the HEX display
//                  (IDLE=00, ACCUM=01, VEND=10, CHANGE=11)
//   COIN_Q/H/D   : coin values in cents
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCUM  = 2'b01,
    S_VEND   = 2'b10,
    S_CHANGE = 2'b11
  } vend_state_t;

  localparam int COIN_Q = 25;
  localparam int COIN_H = 50;
  localparam int COIN_D = 100;

endpackage

// File: rtl/vend_change_dispenser.sv
// rtl/vend_change_dispenser.sv - gap counter and coin selection for returning change
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   in_change_i       : controller is in CHANGE this cycle
//   clear_i           : controller enters CHANGE at the next edge; zero the gap counter
//   credit_i          : current registered credit
//   half_o, quarter_o : change pulse for this cycle (decoded from registers)
//   credit_after_o    : credit once this cycle's pulse, if any, is paid out
//   last_o            : this cycle's pulse empties the credit
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int CREDIT_W  = 9,
  parameter int PULSE_GAP = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_change_i,
  input  logic                clear_i,
  input  logic [CREDIT_W-1:0] credit_i,
  output logic                half_o,
  output logic                quarter_o,
  output logic [CREDIT_W-1:0] credit_after_o,
  output logic                last_o
);

  localparam logic [3:0]          GAP_LOAD = 4'(PULSE_GAP);
  localparam logic [CREDIT_W-1:0] VAL_Q    = CREDIT_W'(COIN_Q);
  localparam logic [CREDIT_W-1:0] VAL_H    = CREDIT_W'(COIN_H);

  logic [3:0] gap_q, gap_d;
  logic       issue;

  // A pulse goes out only when the gap since the previous one has run down.
  assign issue     = in_change_i && (gap_q == 4'd0);
  assign half_o    = issue && (credit_i >= VAL_H);
  assign quarter_o = issue && (credit_i <  VAL_H);

  always_comb begin
    credit_after_o = credit_i;
    if (half_o)
      credit_after_o = credit_i - VAL_H;
    else if (quarter_o)
      credit_after_o = credit_i - VAL_Q;
  end

  assign last_o = issue && (credit_after_o == '0);

  always_comb begin
    gap_d = gap_q;
    if (clear_i)
      gap_d = 4'd0;
    else if (in_change_i)
      gap_d = (gap_q == 4'd0) ? GAP_LOAD : gap_q - 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      gap_q <= 4'd0;
    else
      gap_q <= gap_d;
  end

endmodule

// File: rtl/vend_fsm_param.sv
// rtl/vend_fsm_param.sv - parametrised guffin vending controller
// Ports:
//   CLK, RES                               : clock, synchronous active-high reset
//   coin_en                                : single-cycle strobe qualifying the coin inputs
//   quarter_in, halfDollar_in, dollar_in   : coin identity (exactly one expected)
//   cancel                                 : refund request level
//   guffin                                 : dispense pulse
//   quarter_out, halfDollar_out            : change pulses
//   coin_reject                            : combinational, strobe ignored this cycle
//   credit                                 : current credit in cents
//   state                                  : vend_state_t encoding for the display
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int PRICE     = 100,
  parameter int CREDIT_W  = 9,
  parameter int PULSE_GAP = 1
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic                coin_en,
  input  logic                quarter_in,
  input  logic                halfDollar_in,
  input  logic                dollar_in,
  input  logic                cancel,
  output logic                guffin,
  output logic                quarter_out,
  output logic                halfDollar_out,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state
);

  generate
    if (PRICE % 25 != 0 || PRICE < 25 || PRICE > 400) begin : g_bad_price
      $error("vend_fsm_param: PRICE must be a multiple of 25 in 25..400");
    end
    if ((64'd1 << CREDIT_W) <= 64'(PRICE + 75)) begin : g_bad_width
      $error("vend_fsm_param: CREDIT_W too narrow for PRICE+75");
    end
    if (PULSE_GAP < 0 || PULSE_GAP > 15) begin : g_bad_gap
      $error("vend_fsm_param: PULSE_GAP must be 0..15");
    end
  endgenerate

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  vend_state_t         state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] vend_rem;
  logic [CREDIT_W-1:0] chg_credit;
  logic                coin_ok;
  logic                can_accept;
  logic                enter_change;
  logic                chg_last;

  // Nonzero only for exactly one coin line high; doubles as the one-hot test.
  always_comb begin
    coin_val = '0;
    unique case ({quarter_in, halfDollar_in, dollar_in})
      3'b100:  coin_val = CREDIT_W'(COIN_Q);
      3'b010:  coin_val = CREDIT_W'(COIN_H);
      3'b001:  coin_val = CREDIT_W'(COIN_D);
      default: coin_val = '0;
    endcase
  end

  assign can_accept  = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign coin_ok     = coin_en && (coin_val != '0) && can_accept;
  assign coin_reject = coin_en && !coin_ok;
  assign credit_sum  = credit_q + coin_val;
  assign vend_rem    = credit_q - PRICE_C;

  // A coin in the same cycle as cancel wins, so cancel only counts without one.
  assign enter_change = ((state_q == S_ACCUM) && !coin_ok && cancel) ||
                        ((state_q == S_VEND) && (vend_rem != '0));

  vend_change_dispenser #(
    .CREDIT_W  (CREDIT_W),
    .PULSE_GAP (PULSE_GAP)
  ) u_change (
    .clk_i          (CLK),
    .rst_i          (RES),
    .in_change_i    (state_q == S_CHANGE),
    .clear_i        (enter_change),
    .credit_i       (credit_q),
    .half_o         (halfDollar_out),
    .quarter_o      (quarter_out),
    .credit_after_o (chg_credit),
    .last_o         (chg_last)
  );

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_ACCUM: begin
          if (coin_ok) begin
            credit_q <= credit_sum;
            state_q  <= (credit_sum >= PRICE_C) ? S_VEND : S_ACCUM;
          end else if (enter_change) begin
            state_q <= S_CHANGE;
          end
        end
        S_VEND: begin
          credit_q <= vend_rem;
          state_q  <= (vend_rem != '0) ? S_CHANGE : S_IDLE;
        end
        S_CHANGE: begin
          credit_q <= chg_credit;
          if (chg_last)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign guffin = (state_q == S_VEND);
  assign credit = credit_q;
  assign state  = state_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// tb/tb_vend_fsm_param.sv - directed bench for vend_fsm_param (PRICE=100/GAP=1 and PRICE=75/GAP=0)
module tb_vend_fsm_param;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instance A: PRICE=100, PULSE_GAP=1
  logic       a_res, a_en, a_q, a_h, a_d, a_cancel;
  logic       a_guffin, a_qout, a_hout, a_rej;
  logic [8:0] a_credit;
  logic [1:0] a_state;

  // Instance B: PRICE=75, PULSE_GAP=0
  logic       b_res, b_en, b_q, b_h, b_d, b_cancel;
  logic       b_guffin, b_qout, b_hout, b_rej;
  logic [8:0] b_credit;
  logic [1:0] b_state;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] IDLE = 2'b00, ACCUM = 2'b01, VEND = 2'b10, CHANGE = 2'b11;

  vend_fsm_param #(.PRICE(100), .CREDIT_W(9), .PULSE_GAP(1)) dut_a (
    .CLK(CLK), .RES(a_res), .coin_en(a_en), .quarter_in(a_q), .halfDollar_in(a_h),
    .dollar_in(a_d), .cancel(a_cancel), .guffin(a_guffin), .quarter_out(a_qout),
    .halfDollar_out(a_hout), .coin_reject(a_rej), .credit(a_credit), .state(a_state)
  );

  vend_fsm_param #(.PRICE(75), .CREDIT_W(9), .PULSE_GAP(0)) dut_b (
    .CLK(CLK), .RES(b_res), .coin_en(b_en), .quarter_in(b_q), .halfDollar_in(b_h),
    .dollar_in(b_d), .cancel(b_cancel), .guffin(b_guffin), .quarter_out(b_qout),
    .halfDollar_out(b_hout), .coin_reject(b_rej), .credit(b_credit), .state(b_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs applied before this call are sampled at the edge,
  // outputs are observed 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic a_coin(input logic q, input logic h, input logic d);
    a_en = 1'b1; a_q = q; a_h = h; a_d = d;
  endtask

  task automatic a_idle_in();
    a_en = 1'b0; a_q = 1'b0; a_h = 1'b0; a_d = 1'b0; a_cancel = 1'b0;
  endtask

  // Expect state, credit and all three registered pulses of instance A.
  task automatic a_expect(input string tag, input logic [1:0] st, input int cr,
                          input logic g, input logic h, input logic q);
    check({tag, ".state"},  a_state,  st);
    check({tag, ".credit"}, a_credit, cr);
    check({tag, ".guffin"}, a_guffin, g);
    check({tag, ".half"},   a_hout,   h);
    check({tag, ".quarter"},a_qout,   q);
  endtask

  initial begin
    a_res = 1'b1; a_idle_in();
    b_res = 1'b1; b_en = 1'b0; b_q = 1'b0; b_h = 1'b0; b_d = 1'b0; b_cancel = 1'b0;
    tick(); tick();
    a_res = 1'b0; b_res = 1'b0;
    a_expect("reset", IDLE, 0, 0, 0, 0);
    check("reset.reject", a_rej, 0);
    check("reset_b.state", b_state, IDLE);
    check("reset_b.credit", b_credit, 0);

    // Exact-price dollar: VEND for one cycle, then straight to IDLE.
    a_coin(0, 0, 1); #1;
    check("t1.reject", a_rej, 0);
    tick(); a_idle_in();
    a_expect("t1.vend", VEND, 100, 1, 0, 0);
    tick();
    a_expect("t1.idle", IDLE, 0, 0, 0, 0);

    // 25 + 50 + 100 = 175: guffin, half, gap, quarter, IDLE.
    a_coin(1, 0, 0); tick(); a_idle_in();
    a_expect("t2.q", ACCUM, 25, 0, 0, 0);
    a_coin(0, 1, 0); tick(); a_idle_in();
    a_expect("t2.h", ACCUM, 75, 0, 0, 0);
    a_coin(0, 0, 1); tick(); a_idle_in();
    a_expect("t2.vend", VEND, 175, 1, 0, 0);
    tick();
    a_expect("t2.half", CHANGE, 75, 0, 1, 0);
    tick();
    a_expect("t2.gap", CHANGE, 25, 0, 0, 0);
    tick();
    a_expect("t2.quarter", CHANGE, 25, 0, 0, 1);
    tick();
    a_expect("t2.idle", IDLE, 0, 0, 0, 0);

    // Two quarters, then cancel: one half-dollar refund, no guffin.
    a_coin(1, 0, 0); tick(); a_idle_in();
    // Coin together with cancel: coin wins, cancel ignored this cycle.
    a_coin(1, 0, 0); a_cancel = 1'b1; tick(); a_idle_in();
    a_expect("t3.coin_cancel", ACCUM, 50, 0, 0, 0);
    a_cancel = 1'b1; tick(); a_idle_in();
    a_expect("t3.refund", CHANGE, 50, 0, 1, 0);
    tick();
    a_expect("t3.idle", IDLE, 0, 0, 0, 0);

    // Rejections: two coins at once in IDLE, no coin in ACCUM, coin during CHANGE.
    a_coin(1, 0, 1); #1;
    check("t4.two_coins.reject", a_rej, 1);
    tick(); a_idle_in();
    a_expect("t4.two_coins", IDLE, 0, 0, 0, 0);
    a_coin(1, 0, 0); tick(); a_idle_in();
    a_coin(0, 0, 0); #1;
    check("t4.no_coin.reject", a_rej, 1);
    tick(); a_idle_in();
    a_expect("t4.no_coin", ACCUM, 25, 0, 0, 0);
    a_coin(0, 1, 0); tick(); a_idle_in();
    a_cancel = 1'b1; tick(); a_idle_in();
    a_expect("t4.refund75", CHANGE, 75, 0, 1, 0);
    a_coin(1, 0, 0); #1;
    check("t4.change.reject", a_rej, 1);
    tick(); a_idle_in();
    a_expect("t4.change_gap", CHANGE, 25, 0, 0, 0);

    // Reset in the gap between the two refund pulses.
    a_res = 1'b1; tick(); a_res = 1'b0;
    a_expect("t5.reset", IDLE, 0, 0, 0, 0);
    tick();
    a_expect("t5.after", IDLE, 0, 0, 0, 0);

    // Instance B: dollar at PRICE=75 returns one quarter with no gap.
    b_en = 1'b1; b_d = 1'b1; tick(); b_en = 1'b0; b_d = 1'b0;
    check("t6.vend.state", b_state, VEND);
    check("t6.vend.guffin", b_guffin, 1);
    check("t6.vend.credit", b_credit, 100);
    tick();
    check("t6.chg.state", b_state, CHANGE);
    check("t6.chg.quarter", b_qout, 1);
    check("t6.chg.half", b_hout, 0);
    check("t6.chg.guffin", b_guffin, 0);
    tick();
    check("t6.idle.state", b_state, IDLE);
    check("t6.idle.credit", b_credit, 0);
    check("t6.idle.quarter", b_qout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_fsm_param.md
# vend_fsm_param

Parametrised vending controller for the guffin machine. It accepts debounced coin strobes (quarter, half-dollar, dollar) and accumulates credit against a configurable price. When credit reaches the price it dispenses one guffin, then returns change one coin at a time with a configurable gap between coins. It replaces the fixed seven-state encoder/decoder/register chain and sits between the input debouncers and the HEX display logic, which is driven from `credit` and `state`.

## Interface
- `PRICE`, 100: guffin price in cents; multiple of 25; 25..400.
- `CREDIT_W`, 9: credit register width; must satisfy 2^CREDIT_W > PRICE+75.
- `PULSE_GAP`, 1: idle cycles between successive change pulses; 0..15.
- `CLK` input 1: system clock.
- `RES` input 1: synchronous, active-high reset.
- `coin_en` input 1: single-cycle strobe qualifying the coin inputs; already debounced.
- `quarter_in` input 1: coin is 25.
- `halfDollar_in` input 1: coin is 50.
- `dollar_in` input 1: coin is 100.
- `cancel` input 1: refund request; level, sampled every cycle.
- `guffin` output 1: dispense pulse, 1 cycle.
- `quarter_out` output 1: return one quarter, 1-cycle pulse.
- `halfDollar_out` output 1: return one half-dollar, 1-cycle pulse.
- `coin_reject` output 1: coin strobe ignored, 1-cycle pulse.
- `credit` output CREDIT_W: current credit in cents.
- `state` output 2: IDLE=00, ACCUM=01, VEND=10, CHANGE=11; `state[1]` drives `state_high`, `state[0]` drives `state_low`.

## Operation
- Reset values: state IDLE, `credit`=0, gap counter 0, all pulse outputs 0.
- Coin acceptance happens only in IDLE or ACCUM, on a `coin_en` cycle with exactly one coin input high. The coin value v is 25, 50 or 100.
- On acceptance: `credit` <= `credit`+v. The next state is VEND if `credit`+v >= PRICE, otherwise ACCUM.
- A `coin_en` cycle is rejected if it has zero or more than one coin input high, or if it occurs in VEND or CHANGE. Rejection pulses `coin_reject` in the same cycle (combinational) and leaves state and `credit` unchanged.
- `cancel` in ACCUM goes to CHANGE with credit intact (full refund). `cancel` in IDLE, VEND or CHANGE is ignored.
- If `coin_en` and `cancel` are both asserted in ACCUM, the coin is accepted first and `cancel` is ignored that cycle.
- VEND lasts exactly 1 cycle. `guffin`=1 for that cycle. On exit, `credit` <= `credit`-PRICE and the next state is CHANGE if the remainder is >0, otherwise IDLE. The gap counter is cleared on entry to CHANGE.
- CHANGE, when the gap counter is 0:
  - If `credit` >= 50: `halfDollar_out`=1 and `credit` -= 50.
  - Otherwise: `quarter_out`=1 and `credit` -= 25.
  - The gap counter is loaded with PULSE_GAP.
  - If the new credit is 0, the next state is IDLE.
- CHANGE, when the gap counter is nonzero: the counter decrements and no pulse is issued.
- Credit is always a multiple of 25, so CHANGE always terminates. Maximum credit is PRICE+75, so no overflow check is needed.

## Timing
- Change and vend pulse outputs (`guffin`, `quarter_out`, `halfDollar_out`) are decoded from registered state, gap counter and credit. `coin_reject` is combinational from inputs and state.
- `credit` updates on the accepting edge. VEND is visible the cycle after the coin that completes the price.
- Coin-to-`guffin` latency: 1 cycle. `guffin`-to-first-change-pulse: 1 cycle.
- Change pulses are spaced PULSE_GAP+1 cycles apart.
- State returns to IDLE the cycle after the last change pulse.
- `RES` overrides everything at the next edge, including mid-VEND and mid-CHANGE. Credit is discarded and no further pulses are issued.

## Structure
- Package `vend_pkg` holds the `vend_state_t` enum (2-bit, encoding above) and the localparams `COIN_Q`=25, `COIN_H`=50, `COIN_D`=100.
- Sub-module `vend_change_dispenser` holds the gap counter and the coin-select/decrement logic for CHANGE. The parent holds the state register and the credit register.
- Elaboration-time assertions check that PRICE%25==0 and that the CREDIT_W bound holds.

## Test plan
- PRICE=100, PULSE_GAP=1. Stimulus: RES, then `dollar_in` strobe at cycle 0.
  - Response: `credit`=100 and state VEND at cycle 1; `guffin`=1 at cycle 1; state IDLE and `credit`=0 at cycle 2; no change pulses.
- Stimulus: `quarter_in` strobe, then `halfDollar_in` strobe, then `dollar_in` strobe.
  - Response: credit 25, then 75, then 175; `guffin` pulse; `halfDollar_out` pulse; one gap cycle; `quarter_out` pulse; IDLE with `credit`=0.
- Stimulus: two `quarter_in` strobes, then `cancel`.
  - Response: state CHANGE; exactly one `halfDollar_out` pulse; no `guffin`; IDLE.
- Stimulus: `quarter_in`+`dollar_in` strobed together, and a `quarter_in` strobe during CHANGE.
  - Response: each pulses `coin_reject`; `credit` and state unchanged.
- Stimulus: RES asserted on the cycle between the two pulses of a 75-cent refund.
  - Response: IDLE and `credit`=0 at the next edge; no `quarter_out` pulse.
- PRICE=75, PULSE_GAP=0. Stimulus: `dollar_in` strobe.
  - Response: `guffin` pulse, then `quarter_out` on the next cycle, then IDLE.
